// File: rtl/ram_coeff_streamer_pkg.sv
// Shared definitions for the coefficient streamer: word geometry,
// FSM state encodings and the coefficient unpack helper.
package ram_coeff_streamer_pkg;

  localparam int COEFF_W         = 12;
  localparam int COEFFS_PER_WORD = 8;
  localparam int WORD_W          = COEFF_W * COEFFS_PER_WORD;
  localparam int ADDR_W          = 8;
  localparam int IDX_W           = $clog2(COEFFS_PER_WORD);
  localparam int CNT_W           = ADDR_W + 1;

  // FSM state encoding, kept as plain constants so older blocks can share it
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Coefficient idx of a packed RAM word; idx 0 sits in the low bits
  function automatic logic [COEFF_W-1:0] unpackCoeff(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx
  );
    return word[COEFF_W*idx +: COEFF_W];
  endfunction

endpackage

// File: rtl/ram_coeff_streamer.sv
// Walks a contiguous range of coefficient-RAM words and streams the eight
// packed 12-bit coefficients of each word one per cycle on valid/ready.
// The next word is captured on the same edge that consumes the final
// coefficient of the current one, so a ready sink sees no bubbles.
module ram_coeff_streamer
  import ram_coeff_streamer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    num_words,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WORD_W-1:0]  rdata,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic [COEFF_W-1:0] coeff_data,
  output logic               coeff_last,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_raddr;
  logic [WORD_W-1:0]  r_buffer;
  logic [CNT_W-1:0]   r_wordsLeft;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;

  logic               w_streaming;
  logic               w_handshake;
  logic               w_lastIdx;
  logic               w_noWordsLeft;
  logic               w_capture;

  assign w_streaming   = (r_state == ST_STREAM);
  assign w_handshake   = w_streaming && coeff_ready;
  assign w_lastIdx     = (r_idx == IDX_W'(COEFFS_PER_WORD - 1));
  assign w_noWordsLeft = (r_wordsLeft == '0);
  // A RAM word is latched in LOAD and on the final handshake of a word
  // whenever more words remain
  assign w_capture     = (r_state == ST_LOAD) ||
                         (w_handshake && w_lastIdx && !w_noWordsLeft);

  // Next-state selection; start is only looked at while idle
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            w_nextState = ST_FINISH;
          end else begin
            w_nextState = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        w_nextState = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_handshake && w_lastIdx && w_noWordsLeft) begin
          w_nextState = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Read address and remaining-word count advance on every word capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr     <= '0;
      r_wordsLeft <= '0;
    end else if ((r_state == ST_IDLE) && start && (num_words != '0)) begin
      r_raddr     <= base_addr;
      r_wordsLeft <= num_words;
    end else if (w_capture) begin
      r_raddr     <= r_raddr + ADDR_W'(1);
      r_wordsLeft <= r_wordsLeft - CNT_W'(1);
    end
  end

  // Word buffer and coefficient index; a capture restarts the index at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buffer <= '0;
      r_idx    <= '0;
    end else if (w_capture) begin
      r_buffer <= rdata;
      r_idx    <= '0;
    end else if (w_handshake && !w_lastIdx) begin
      r_idx    <= r_idx + IDX_W'(1);
    end
  end

  // Busy covers an accepted start through the completion cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_busy <= 1'b1;
    end else if (r_state == ST_FINISH) begin
      r_busy <= 1'b0;
    end
  end

  assign raddr       = r_raddr;
  assign coeff_valid = w_streaming;
  assign coeff_data  = unpackCoeff(r_buffer, r_idx);
  assign coeff_last  = w_streaming && w_lastIdx && w_noWordsLeft;
  assign busy        = r_busy;
  assign done        = (r_state == ST_FINISH);

endmodule
